// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//   Per-bit debouncer and edge detector for board inputs (buttons, DIP
//   switches). Sits directly behind the two-flop synchroniser in the same
//   dest_clk domain. Each bit keeps its own stability counter. The debounced
//   level flips only after STABLE_COUNT consecutive sampled mismatches. Any
//   matching sample restarts the count.
//
// Parameters
//   INPUT_WIDTH  : number of independent input bits
//   CNT_WIDTH    : width of each per-bit stability counter
//   STABLE_COUNT : consecutive mismatching edges before a flip (1..2^CNT_WIDTH-1)
//   RESET_VALUE  : debounced level held during reset
//
// Ports
//   dest_clk     in   clock, rising edge
//   dest_resetn  in   asynchronous active-low reset
//   sync_data    in   synchronised input levels
//   clear_flag   in   single-cycle request to clear change_flag
//   db_data      out  debounced levels
//   rise_pulse   out  one-cycle pulse on a debounced 0->1 transition
//   fall_pulse   out  one-cycle pulse on a debounced 1->0 transition
//   change_flag  out  sticky per-bit transition flag
// -----------------------------------------------------------------------------
module sync_debounce #(
  parameter int unsigned                   INPUT_WIDTH  = 8,
  parameter int unsigned                   CNT_WIDTH    = 16,
  parameter int unsigned                   STABLE_COUNT = 50000,
  parameter logic [INPUT_WIDTH-1:0]        RESET_VALUE  = '0
) (
  input  logic                   dest_clk,
  input  logic                   dest_resetn,
  input  logic [INPUT_WIDTH-1:0] sync_data,
  input  logic                   clear_flag,
  output logic [INPUT_WIDTH-1:0] db_data,
  output logic [INPUT_WIDTH-1:0] rise_pulse,
  output logic [INPUT_WIDTH-1:0] fall_pulse,
  output logic [INPUT_WIDTH-1:0] change_flag
);

  // Terminal count: the mismatch sampled while the counter holds this value
  // is the STABLE_COUNT-th one, so the level flips on that edge.
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic [CNT_WIDTH-1:0]   r_cnt [INPUT_WIDTH];
  logic [INPUT_WIDTH-1:0] r_db;
  logic [INPUT_WIDTH-1:0] r_rise;
  logic [INPUT_WIDTH-1:0] r_fall;
  logic [INPUT_WIDTH-1:0] r_flag;

  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_db   <= RESET_VALUE;
      r_rise <= '0;
      r_fall <= '0;
      r_flag <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      // Clear first; a flip below on the same edge overrides it for that bit.
      if (clear_flag) begin
        r_flag <= '0;
      end
      for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
        if (sync_data[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_LAST) begin
          r_db[i]   <= sync_data[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= sync_data[i];
          r_fall[i] <= ~sync_data[i];
          r_flag[i] <= 1'b1;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign db_data     = r_db;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign change_flag = r_flag;

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

  logic       dest_clk;
  logic       dest_resetn;
  logic [7:0] sync_data;
  logic       clear_flag;
  logic [7:0] db_data;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
  logic [7:0] change_flag;

  int unsigned checks;
  int unsigned failures;

  sync_debounce #(
    .INPUT_WIDTH  (8),
    .CNT_WIDTH    (16),
    .STABLE_COUNT (4),
    .RESET_VALUE  (8'h00)
  ) dut (
    .dest_clk    (dest_clk),
    .dest_resetn (dest_resetn),
    .sync_data   (sync_data),
    .clear_flag  (clear_flag),
    .db_data     (db_data),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .change_flag (change_flag)
  );

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_db, input logic [7:0] e_rise,
                           input logic [7:0] e_fall, input logic [7:0] e_flag);
    check({tag, ".db"},   db_data,     e_db);
    check({tag, ".rise"}, rise_pulse,  e_rise);
    check({tag, ".fall"}, fall_pulse,  e_fall);
    check({tag, ".flag"}, change_flag, e_flag);
    check({tag, ".both"}, rise_pulse & fall_pulse, 8'h00);
  endtask

  // Advance one rising edge, sample 1ns later, compare everything.
  task automatic step(input string tag, input logic [7:0] e_db, input logic [7:0] e_rise,
                      input logic [7:0] e_fall, input logic [7:0] e_flag);
    @(posedge dest_clk);
    #1;
    check_all(tag, e_db, e_rise, e_fall, e_flag);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    dest_resetn = 1'b0;
    sync_data   = 8'h00;
    clear_flag  = 1'b0;

    // Reset state
    #2;
    check_all("reset_async", 8'h00, 8'h00, 8'h00, 8'h00);
    step("reset_held", 8'h00, 8'h00, 8'h00, 8'h00);
    dest_resetn = 1'b1;
    step("idle0", 8'h00, 8'h00, 8'h00, 8'h00);
    step("idle1", 8'h00, 8'h00, 8'h00, 8'h00);

    // Bit 0 rises: flips on 4th mismatching edge
    sync_data = 8'h01;
    step("b0_e1", 8'h00, 8'h00, 8'h00, 8'h00);
    step("b0_e2", 8'h00, 8'h00, 8'h00, 8'h00);
    step("b0_e3", 8'h00, 8'h00, 8'h00, 8'h00);
    step("b0_e4", 8'h01, 8'h01, 8'h00, 8'h01);
    step("b0_e5", 8'h01, 8'h00, 8'h00, 8'h01);

    // Glitch on bit 1: 3 high, 1 low, 3 high -> no flip; 4th high flips
    sync_data = 8'h03;
    for (int k = 0; k < 3; k++) step("gl_a", 8'h01, 8'h00, 8'h00, 8'h01);
    sync_data = 8'h01;
    step("gl_low", 8'h01, 8'h00, 8'h00, 8'h01);
    sync_data = 8'h03;
    for (int k = 0; k < 3; k++) step("gl_b", 8'h01, 8'h00, 8'h00, 8'h01);
    step("gl_flip", 8'h03, 8'h02, 8'h00, 8'h03);
    step("gl_after", 8'h03, 8'h00, 8'h00, 8'h03);

    // Plain clear of all flags
    clear_flag = 1'b1;
    step("clr", 8'h03, 8'h00, 8'h00, 8'h00);
    clear_flag = 1'b0;

    // Bits 2 and 7 together
    sync_data = 8'h87;
    for (int k = 0; k < 3; k++) step("b27_cnt", 8'h03, 8'h00, 8'h00, 8'h00);
    step("b27_flip", 8'h87, 8'h84, 8'h00, 8'h84);
    // Bit 0 drops
    sync_data = 8'h86;
    for (int k = 0; k < 3; k++) step("b0f_cnt", 8'h87, 8'h00, 8'h00, 8'h84);
    step("b0f_flip", 8'h86, 8'h00, 8'h01, 8'h85);
    step("b0f_after", 8'h86, 8'h00, 8'h00, 8'h85);

    // Clear coincident with a rise on bit 3: set wins on bit 3
    sync_data = 8'h8E;
    for (int k = 0; k < 3; k++) step("b3_cnt", 8'h86, 8'h00, 8'h00, 8'h85);
    clear_flag = 1'b1;
    step("b3_clrset", 8'h8E, 8'h08, 8'h00, 8'h08);
    clear_flag = 1'b0;
    step("b3_after", 8'h8E, 8'h00, 8'h00, 8'h08);

    // Reset mid-count on bit 4
    sync_data = 8'h9E;
    step("b4_m1", 8'h8E, 8'h00, 8'h00, 8'h08);
    step("b4_m2", 8'h8E, 8'h00, 8'h00, 8'h08);
    dest_resetn = 1'b0;
    #1;
    check_all("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
    step("rst_mid_held", 8'h00, 8'h00, 8'h00, 8'h00);
    dest_resetn = 1'b1;
    // Every high bit of 9E now mismatches from zero and needs 4 full edges
    step("post_e1", 8'h00, 8'h00, 8'h00, 8'h00);
    step("post_e2", 8'h00, 8'h00, 8'h00, 8'h00);
    step("post_e3", 8'h00, 8'h00, 8'h00, 8'h00);
    step("post_e4", 8'h9E, 8'h9E, 8'h00, 8'h9E);
    step("post_e5", 8'h9E, 8'h00, 8'h00, 8'h9E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
